// File: rtl/bbuf_pkg.sv
// Shared types and geometry helpers for the bias-buffer write controller.
// Beat/row geometry is derived here so the top and the counter agree on it.
package bbuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } bbuf_state_e;

    function automatic int banks_per_beat(input int ddr_bandwidth, input int write_width);
        return (write_width > 0) ? (ddr_bandwidth / write_width) : 0;
    endfunction

    function automatic int beats_per_row(input int num_banks, input int banks_per_beat_v);
        return (banks_per_beat_v > 0) ? (num_banks / banks_per_beat_v) : 0;
    endfunction

    // A one-beat row still needs a 1-bit index so the counter ports stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bbuf_write_ctrl_if.sv
// Load-control, DDR stream and bank-write bus of the bias-buffer write controller.
// The controller uses the slave view; whoever drives loads and beats uses master.
interface bbuf_write_ctrl_if #(
    parameter int DDR_BANDWIDTH    = 512,
    parameter int NUM_BANKS        = 64,
    parameter int WRITE_ADDR_WIDTH = 8
);

    logic                                  start;
    logic [WRITE_ADDR_WIDTH-1:0]           base_addr;
    logic [WRITE_ADDR_WIDTH:0]             num_rows;
    logic                                  ddr_valid;
    logic                                  ddr_ready;
    logic [DDR_BANDWIDTH-1:0]              ddr_data;
    logic [NUM_BANKS-1:0]                  bs_write_req;
    logic [NUM_BANKS*WRITE_ADDR_WIDTH-1:0] bs_write_addr;
    logic [DDR_BANDWIDTH-1:0]              bs_write_data;
    logic                                  busy;
    logic                                  done;

    modport master (
        output start, base_addr, num_rows, ddr_valid, ddr_data,
        input  ddr_ready, bs_write_req, bs_write_addr, bs_write_data, busy, done
    );

    modport slave (
        input  start, base_addr, num_rows, ddr_valid, ddr_data,
        output ddr_ready, bs_write_req, bs_write_addr, bs_write_data, busy, done
    );

endinterface

// File: rtl/bbuf_beat_counter.sv
// Beat-within-row and row counters for one load, plus the final-beat flag.
// Cleared when a load is accepted, stepped once per accepted DDR beat.
module bbuf_beat_counter
    import bbuf_pkg::*;
#(
    parameter int BEATS_PER_ROW = 1,
    parameter int BEAT_W        = idx_width(BEATS_PER_ROW),
    parameter int ROW_W         = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic [ROW_W-1:0]  num_rows,
    output logic [BEAT_W-1:0] beat_idx,
    output logic [ROW_W-1:0]  row_idx,
    output logic              last_beat
);

    logic [BEAT_W-1:0] beat_idx_r;
    logic [ROW_W-1:0]  row_idx_r;
    logic              beat_wrap_s;

    assign beat_wrap_s = (beat_idx_r == BEAT_W'(BEATS_PER_ROW - 1));

    // Beat index wraps at the end of a row and carries into the row index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_idx_r <= '0;
            row_idx_r  <= '0;
        end else if (clear) begin
            beat_idx_r <= '0;
            row_idx_r  <= '0;
        end else if (advance) begin
            if (beat_wrap_s) begin
                beat_idx_r <= '0;
                row_idx_r  <= row_idx_r + ROW_W'(1);
            end else begin
                beat_idx_r <= beat_idx_r + BEAT_W'(1);
                row_idx_r  <= row_idx_r;
            end
        end else begin
            beat_idx_r <= beat_idx_r;
            row_idx_r  <= row_idx_r;
        end
    end

    assign beat_idx  = beat_idx_r;
    assign row_idx   = row_idx_r;
    assign last_beat = beat_wrap_s && (row_idx_r == (num_rows - ROW_W'(1)));

endmodule

// File: rtl/bbuf_write_ctrl.sv
// Streams DDR beats into the bias-buffer banks: each accepted beat becomes one
// registered write to the bank group it covers, at row base_addr + row index.
module bbuf_write_ctrl
    import bbuf_pkg::*;
#(
    parameter int DDR_BANDWIDTH    = 512,
    parameter int NUM_BANKS        = 64,
    parameter int WRITE_WIDTH      = 8,
    parameter int WRITE_ADDR_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    bbuf_write_ctrl_if.slave  bus
);

    localparam int BANKS_PER_BEAT = banks_per_beat(DDR_BANDWIDTH, WRITE_WIDTH);
    localparam int BEATS_PER_ROW  = beats_per_row(NUM_BANKS, BANKS_PER_BEAT);
    localparam int BEAT_W         = idx_width(BEATS_PER_ROW);
    localparam int ROW_W          = WRITE_ADDR_WIDTH + 1;
    localparam int SAFE_BPB       = (BANKS_PER_BEAT < 1) ? 1 : BANKS_PER_BEAT;

    generate
        if ((BANKS_PER_BEAT < 1) || (BEATS_PER_ROW < 1) ||
            ((DDR_BANDWIDTH % WRITE_WIDTH) != 0) || ((NUM_BANKS % SAFE_BPB) != 0)) begin : g_bad_cfg
            $error("bbuf_write_ctrl: DDR_BANDWIDTH/WRITE_WIDTH and NUM_BANKS/BANKS_PER_BEAT must be integers >= 1");
        end
    endgenerate

    bbuf_state_e                           state_r;
    bbuf_state_e                           state_next_s;
    logic [WRITE_ADDR_WIDTH-1:0]           base_addr_r;
    logic [ROW_W-1:0]                      num_rows_r;
    logic                                  start_ok_s;
    logic                                  handshake_s;
    logic                                  ready_next_s;
    logic                                  busy_next_s;
    logic                                  done_next_s;
    logic                                  ready_r;
    logic                                  busy_r;
    logic                                  done_r;
    logic [BEAT_W-1:0]                     beat_idx_s;
    logic [ROW_W-1:0]                      row_idx_s;
    logic                                  last_beat_s;
    logic [NUM_BANKS-1:0]                  grp_mask_s;
    logic [WRITE_ADDR_WIDTH-1:0]           row_addr_s;
    logic [NUM_BANKS-1:0]                  write_req_r;
    logic [NUM_BANKS*WRITE_ADDR_WIDTH-1:0] write_addr_r;
    logic [DDR_BANDWIDTH-1:0]              write_data_r;

    assign start_ok_s  = bus.start & (state_r == ST_IDLE);
    assign handshake_s = bus.ddr_valid & ready_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a zero-row load goes straight to DONE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = (bus.num_rows != '0) ? ST_LOAD : ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (handshake_s && last_beat_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the next state so they can be registered.
    always_comb begin
        ready_next_s = 1'b0;
        busy_next_s  = 1'b0;
        done_next_s  = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                ready_next_s = 1'b0;
            end
            ST_LOAD: begin
                ready_next_s = 1'b1;
                busy_next_s  = 1'b1;
            end
            ST_DONE: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b1;
            end
            default: begin
                ready_next_s = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= ready_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    // Load parameters are captured only when a start is accepted in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_addr_r <= '0;
            num_rows_r  <= '0;
        end else if (start_ok_s) begin
            base_addr_r <= bus.base_addr;
            num_rows_r  <= bus.num_rows;
        end else begin
            base_addr_r <= base_addr_r;
            num_rows_r  <= num_rows_r;
        end
    end

    bbuf_beat_counter #(
        .BEATS_PER_ROW (BEATS_PER_ROW),
        .BEAT_W        (BEAT_W),
        .ROW_W         (ROW_W)
    ) u_beat_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok_s),
        .advance   (handshake_s),
        .num_rows  (num_rows_r),
        .beat_idx  (beat_idx_s),
        .row_idx   (row_idx_s),
        .last_beat (last_beat_s)
    );

    // Beat b of a row feeds the contiguous group of banks it spans.
    for (genvar g = 0; g < BEATS_PER_ROW; g++) begin : g_grp
        assign grp_mask_s[g*BANKS_PER_BEAT +: BANKS_PER_BEAT] =
            {BANKS_PER_BEAT{beat_idx_s == BEAT_W'(g)}};
    end

    // Row address wraps modulo the bank depth by truncation.
    assign row_addr_s = WRITE_ADDR_WIDTH'({1'b0, base_addr_r} + row_idx_s);

    // Write request lasts one cycle per handshake; address and data hold afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_req_r  <= '0;
            write_addr_r <= '0;
            write_data_r <= '0;
        end else if (handshake_s) begin
            write_req_r  <= grp_mask_s;
            write_addr_r <= {NUM_BANKS{row_addr_s}};
            write_data_r <= bus.ddr_data;
        end else begin
            write_req_r  <= '0;
            write_addr_r <= write_addr_r;
            write_data_r <= write_data_r;
        end
    end

    assign bus.ddr_ready     = ready_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.bs_write_req  = write_req_r;
    assign bus.bs_write_addr = write_addr_r;
    assign bus.bs_write_data = write_data_r;

endmodule
